// File: rtl/neuron_preact_mac.sv
// neuron_preact_mac
//   Serial multiply-accumulate producing one neuron pre-activation
//   z = sum(x_i * w_i) + bias, packed to signed Q5.26 for the tanh stage.
//   Terms arrive over a valid/ready stream. The result is held on oz with
//   wa=0 until the consumer pulses ack.
//
//   Build option: define SAT_EN to saturate oz when packing overflows.
//   Without it, oz wraps (two's complement). ovf reports overflow in both builds.
//
// Ports
//   clk       clock, all state on posedge
//   rst       asynchronous active-low reset
//   locked    synchronous abort back to the reset state
//   require   start request (honoured only when idle)
//   x_in      activation term, signed Q5.26
//   w_in      weight term, signed Q5.26
//   in_valid  x_in/w_in valid
//   in_ready  a term is accepted when in_valid & in_ready
//   bias      bias, signed Q5.26, sampled in the bias step
//   ack       consumer done with oz (honoured only while holding)
//   oz        packed pre-activation, signed Q5.26
//   wa        1 = oz not valid, 0 = oz valid and stable
//   busy      1 while a computation is in progress
//   ovf       packing of the current result overflowed DW
module neuron_preact_mac #(
    parameter int N_IN  = 8,
    parameter int DW    = 32,
    parameter int FRAC  = 26,
    parameter int GUARD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          locked,
    input  logic          require,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] w_in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] bias,
    input  logic          ack,
    output logic [DW-1:0] oz,
    output logic          wa,
    output logic          busy,
    output logic          ovf
);

    localparam int ACC_W = 2 * DW + GUARD;
    localparam int CNT_W = $clog2(N_IN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_DRAIN,
        S_BIAS,
        S_PACK,
        S_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [2*DW-1:0]     prod_q, prod_d;
    logic                prod_v_q, prod_v_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DW-1:0]       oz_q, oz_d;
    logic                wa_q, wa_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;

    logic                accept;
    logic [ACC_W-1:0]    prod_ext;
    logic [ACC_W-1:0]    bias_ext;
    logic [ACC_W-1:0]    r_full;
    logic [ACC_W-DW:0]   r_upper;
    logic                r_ovf;
    logic [DW-1:0]       packed_val;

    assign accept   = in_valid & in_ready_q;
    assign prod_ext = {{GUARD{prod_q[2*DW-1]}}, prod_q};
    assign bias_ext = {{(ACC_W-DW){bias[DW-1]}}, bias} << FRAC;

    // Arithmetic shift: truncation toward -inf.
    assign r_full  = $signed(acc_q) >>> FRAC;
    assign r_upper = r_full[ACC_W-1:DW-1];
    // The result fits DW only if the sign bit and all bits above it agree.
    assign r_ovf   = (|r_upper) && !(&r_upper);

`ifdef SAT_EN
    always_comb begin
        packed_val = r_full[DW-1:0];
        if (r_ovf) begin
            packed_val = r_full[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end
`else
    assign packed_val = r_full[DW-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_v_d   = prod_v_q;
        count_d    = count_q;
        oz_d       = oz_q;
        wa_d       = wa_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (require) begin
                    acc_d      = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    prod_v_d   = 1'b0;
                    in_ready_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_ACC;
                end
            end
            S_ACC: begin
                // Products are added one cycle after they are formed.
                if (prod_v_q) begin
                    acc_d = acc_q + prod_ext;
                end
                prod_v_d = accept;
                if (accept) begin
                    prod_d  = $signed({{DW{x_in[DW-1]}}, x_in}) * $signed({{DW{w_in[DW-1]}}, w_in});
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N_IN - 1)) begin
                        in_ready_d = 1'b0;
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (prod_v_q) begin
                    acc_d = acc_q + prod_ext;
                end
                prod_v_d = 1'b0;
                state_d  = S_BIAS;
            end
            S_BIAS: begin
                acc_d   = acc_q + bias_ext;
                state_d = S_PACK;
            end
            S_PACK: begin
                oz_d    = packed_val;
                ovf_d   = r_ovf;
                wa_d    = 1'b0;
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (ack) begin
                    wa_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort: everything returns to its reset value on this edge.
        if (locked) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            prod_d     = '0;
            prod_v_d   = 1'b0;
            count_d    = '0;
            oz_d       = '0;
            wa_d       = 1'b1;
            in_ready_d = 1'b0;
            busy_d     = 1'b0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            count_q    <= '0;
            oz_q       <= '0;
            wa_q       <= 1'b1;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_v_q   <= prod_v_d;
            count_q    <= count_d;
            oz_q       <= oz_d;
            wa_q       <= wa_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready = in_ready_q;
    assign oz       = oz_q;
    assign wa       = wa_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_neuron_preact_mac.sv
// Directed testbench for neuron_preact_mac with N_IN = 4.
// Inputs change on the falling edge and outputs are sampled there too.
module tb_neuron_preact_mac;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          locked = 1'b0;
    logic          require = 1'b0;
    logic [DW-1:0] x_in = '0;
    logic [DW-1:0] w_in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] bias = '0;
    logic          ack = 1'b0;
    logic [DW-1:0] oz;
    logic          wa;
    logic          busy;
    logic          ovf;

    int checks = 0;
    int errors = 0;

    neuron_preact_mac #(.N_IN(4), .DW(32), .FRAC(26), .GUARD(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .require  (require),
        .x_in     (x_in),
        .w_in     (w_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bias     (bias),
        .ack      (ack),
        .oz       (oz),
        .wa       (wa),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    // Starts a computation, streams four identical terms, checks the
    // wa latency and the packed result. Starts and ends on a falling edge.
    // gap=1 drives valid in a 1,0,0 pattern and keeps valid high after the
    // last accept. poke=1 pulses require/ack while accumulating.
    task automatic run_calc(input string tag, input logic [31:0] x, input logic [31:0] w,
                            input logic [31:0] b, input bit gap, input bit poke,
                            input logic [31:0] exp_oz, input logic exp_ovf);
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        bias = b;
        require = 1'b1;
        @(negedge clk);
        require = 1'b0;
        while (n < 4 && cyc < 100) begin
            x_in = x;
            w_in = w;
            in_valid = !gap || (cyc % 3 == 0);
            require = poke && (cyc == 1);
            ack = poke && (cyc == 1);
            if (in_valid && in_ready) n++;
            cyc++;
            @(negedge clk);
        end
        require = 1'b0;
        ack = 1'b0;
        chk({tag, ".accepts"}, 64'(n), 64'd4);
        in_valid = gap;
        chk({tag, ".ready_off"}, 64'(in_ready), 64'd0);
        chk({tag, ".wa_e0"}, 64'(wa), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd1);
        @(negedge clk);
        chk({tag, ".wa_e1"}, 64'(wa), 64'd1);
        @(negedge clk);
        chk({tag, ".wa_e2"}, 64'(wa), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".wa_e3"}, 64'(wa), 64'd0);
        chk({tag, ".oz"}, 64'(oz), 64'(exp_oz));
        chk({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    endtask

    task automatic release_hold(input string tag, input bit with_req);
        ack = 1'b1;
        require = with_req;
        @(negedge clk);
        ack = 1'b0;
        require = 1'b0;
        chk({tag, ".wa_rel"}, 64'(wa), 64'd1);
        chk({tag, ".busy_rel"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, ".stay_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] hold_oz;
        int n;

        // Reset state
        @(negedge clk);
        chk("rst.oz", 64'(oz), 64'd0);
        chk("rst.wa", 64'(wa), 64'd1);
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.ovf", 64'(ovf), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // ack while idle has no effect
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("idle_ack.busy", 64'(busy), 64'd0);
        chk("idle_ack.wa", 64'(wa), 64'd1);

        // 1: 1.0*0.5 x4 + 0.25 = 2.25
        run_calc("t1", 32'h04000000, 32'h02000000, 32'h01000000, 1'b0, 1'b0, 32'h09000000, 1'b0);
        release_hold("t1", 1'b0);

        // 2: -1.0*1.5 x4 = -6.0, with stray require/ack while accumulating
        run_calc("t2", 32'hFC000000, 32'h06000000, 32'h00000000, 1'b0, 1'b1, 32'hE8000000, 1'b0);
        release_hold("t2", 1'b0);

        // 3: 4.0*4.0 x4 = 64.0 overflows
`ifdef SAT_EN
        run_calc("t3", 32'h10000000, 32'h10000000, 32'h00000000, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1);
`else
        run_calc("t3", 32'h10000000, 32'h10000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b1);
`endif
        release_hold("t3", 1'b0);

        // 4: gaps in valid, extra valids after the fourth accept ignored
        run_calc("t4", 32'h04000000, 32'h02000000, 32'h01000000, 1'b1, 1'b0, 32'h09000000, 1'b0);
        release_hold("t4", 1'b0);

        // 5: abort after two accepts
        require = 1'b1;
        @(negedge clk);
        require = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            x_in = 32'h7FFFFFFF;
            w_in = 32'h7FFFFFFF;
            in_valid = 1'b1;
            if (in_ready) n++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t5.accepts", 64'(n), 64'd2);
        locked = 1'b1;
        @(negedge clk);
        locked = 1'b0;
        chk("t5.busy", 64'(busy), 64'd0);
        chk("t5.wa", 64'(wa), 64'd1);
        chk("t5.oz", 64'(oz), 64'd0);
        chk("t5.in_ready", 64'(in_ready), 64'd0);
        run_calc("t5b", 32'h04000000, 32'h02000000, 32'h01000000, 1'b0, 1'b0, 32'h09000000, 1'b0);
        release_hold("t5b", 1'b0);

        // 6: long hold, then ack and require together
        run_calc("t6", 32'hFC000000, 32'h06000000, 32'h01000000, 1'b0, 1'b0, 32'hE9000000, 1'b0);
        hold_oz = oz;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c % 5 == 4) begin
                chk("t6.hold_oz", 64'(oz), 64'h00000000E9000000);
                chk("t6.hold_wa", 64'(wa), 64'd0);
            end
        end
        chk("t6.hold_first", 64'(oz), 64'(hold_oz));
        release_hold("t6", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
